// File: rtl/inst_buffer_if.sv
// Fetch/decode handshake bundle for the dual-slot instruction buffer.
interface inst_buffer_if #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [INST_WIDTH-1:0] in_inst_0;
  logic [INST_WIDTH-1:0] in_inst_1;
  logic [ADDR_WIDTH-1:0] in_pc;
  logic [1:0]            in_valid;
  logic                  in_ready;
  logic [INST_WIDTH-1:0] out_inst_0;
  logic [INST_WIDTH-1:0] out_inst_1;
  logic [ADDR_WIDTH-1:0] out_pc_0;
  logic [ADDR_WIDTH-1:0] out_pc_1;
  logic [1:0]            out_valid;
  logic [1:0]            out_accept;
  logic [CW-1:0]         count;

  modport master (
    output in_inst_0, in_inst_1, in_pc, in_valid, out_accept,
    input  in_ready, out_inst_0, out_inst_1, out_pc_0, out_pc_1,
    input  out_valid, count
  );

  modport slave (
    input  in_inst_0, in_inst_1, in_pc, in_valid, out_accept,
    output in_ready, out_inst_0, out_inst_1, out_pc_0, out_pc_1,
    output out_valid, count
  );
endinterface

// File: rtl/inst_buffer.sv
// Dual-slot fetch-to-decode instruction FIFO.
// Define INST_BUFFER_BYPASS_EN for same-cycle pass-through when empty.
module inst_buffer #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PC_STEP    = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  inst_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL2 = CW'(DEPTH - 2);

  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

  logic [AW-1:0] head_q, head_d, head_p1;
  logic [AW-1:0] tail_q, tail_d, tail_p1;
  logic [CW-1:0] count_q, count_d;

  logic                  ready;
  logic                  byp;
  logic [1:0]            n_in, n_acc, n_skip, n_wr, n_pop;
  logic [ADDR_WIDTH-1:0] pc1;
  logic [INST_WIDTH-1:0] e_inst0, e_inst1, w_inst0;
  logic [ADDR_WIDTH-1:0] e_pc0, e_pc1, w_pc0;

  assign ready   = count_q <= FULL2;
  assign pc1     = bus.in_pc + ADDR_WIDTH'(PC_STEP);
  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Batch compaction: a lone slot-1 entry moves to the front
  always_comb begin
    e_inst0 = bus.in_valid[0] ? bus.in_inst_0 : bus.in_inst_1;
    e_pc0   = bus.in_valid[0] ? bus.in_pc : pc1;
    e_inst1 = bus.in_inst_1;
    e_pc1   = pc1;
    n_in    = 2'd0;
    if (ready) begin
      case (bus.in_valid)
        2'b11:        n_in = 2'd2;
        2'b01, 2'b10: n_in = 2'd1;
        default:      n_in = 2'd0;
      endcase
    end
  end

  always_comb begin
    n_acc = 2'd0;
    case (bus.out_accept)
      2'b01:   n_acc = 2'd1;
      2'b11:   n_acc = 2'd2;
      default: n_acc = 2'd0;
    endcase
  end

`ifdef INST_BUFFER_BYPASS_EN
  assign byp = (count_q == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  // Bypassed entries consumed this cycle are never written
  always_comb begin
    n_skip = 2'd0;
    n_pop  = 2'd0;
    if (byp) begin
      n_skip = (n_acc < n_in) ? n_acc : n_in;
    end else begin
      n_pop = (count_q < CW'(n_acc)) ? count_q[1:0] : n_acc;
    end
    n_wr    = n_in - n_skip;
    w_inst0 = (n_skip == 2'd0) ? e_inst0 : e_inst1;
    w_pc0   = (n_skip == 2'd0) ? e_pc0 : e_pc1;
  end

  always_comb begin
    count_d = count_q + CW'(n_wr) - CW'(n_pop);
    head_d  = head_q + AW'(n_pop);
    tail_d  = tail_q + AW'(n_wr);
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && n_wr != 2'd0) begin
      inst_q[tail_q] <= w_inst0;
      pc_q[tail_q]   <= w_pc0;
    end
    if (!flush && n_wr == 2'd2) begin
      inst_q[tail_p1] <= e_inst1;
      pc_q[tail_p1]   <= e_pc1;
    end
  end

  always_comb begin
    bus.out_inst_0 = '0;
    bus.out_inst_1 = '0;
    bus.out_pc_0   = '0;
    bus.out_pc_1   = '0;
    bus.out_valid  = 2'b00;
    if (count_q != '0) begin
      bus.out_valid[0] = 1'b1;
      bus.out_inst_0   = inst_q[head_q];
      bus.out_pc_0     = pc_q[head_q];
    end
    if (count_q >= CW'(2)) begin
      bus.out_valid[1] = 1'b1;
      bus.out_inst_1   = inst_q[head_p1];
      bus.out_pc_1     = pc_q[head_p1];
    end
    if (byp && n_in != 2'd0) begin
      bus.out_valid[0] = 1'b1;
      bus.out_inst_0   = e_inst0;
      bus.out_pc_0     = e_pc0;
    end
    if (byp && n_in == 2'd2) begin
      bus.out_valid[1] = 1'b1;
      bus.out_inst_1   = e_inst1;
      bus.out_pc_1     = e_pc1;
    end
  end

  assign bus.in_ready = ready;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: directed batches, monitor-side pop checks.
module tb_inst_buffer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int checks = 0;
  int errors = 0;
  int mdl_cnt = 0;
  logic [63:0] exp_q [$];

  inst_buffer_if #(.INST_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) bus ();

  inst_buffer #(
    .INST_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pop(input int slot, input logic [31:0] inst,
                         input logic [31:0] pc);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL pop%0d: got pc %0h expected nothing", slot, pc);
    end else begin
      e = exp_q.pop_front();
      if ({inst, pc} !== e) begin
        errors++;
        $display("FAIL pop%0d: got %0h expected %0h", slot, {inst, pc}, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_accept[0] && bus.out_valid[0])
        chk_pop(0, bus.out_inst_0, bus.out_pc_0);
      if (bus.out_accept == 2'b11 && bus.out_valid[1])
        chk_pop(1, bus.out_inst_1, bus.out_pc_1);
    end
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] pc,
                       input logic [1:0] acc);
    bus.in_valid   = v;
    bus.in_pc      = pc;
    bus.in_inst_0  = f(pc);
    bus.in_inst_1  = f(pc + 32'd4);
    bus.out_accept = acc;
  endtask

  task automatic step();
    int np, acc, avail, npop;
    np = 0;
    if (mdl_cnt <= DEPTH - 2)
      np = int'(bus.in_valid[0]) + int'(bus.in_valid[1]);
    if (!flush) begin
      if (bus.in_valid[0] && np > 0)
        exp_q.push_back({f(bus.in_pc), bus.in_pc});
      if (bus.in_valid[1] && np > 0)
        exp_q.push_back({f(bus.in_pc + 32'd4), bus.in_pc + 32'd4});
    end
    acc = (bus.out_accept == 2'b11) ? 2 : (bus.out_accept == 2'b01) ? 1 : 0;
    avail = mdl_cnt;
`ifdef INST_BUFFER_BYPASS_EN
    if (mdl_cnt == 0) avail = np;
`endif
    npop = (acc < avail) ? acc : avail;
    @(negedge clk);
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      mdl_cnt = mdl_cnt + np - npop;
    end
    #1;
    check("count_model", 64'(bus.count), 64'(mdl_cnt));
  endtask

  initial begin
    drive(2'b00, 32'h0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_pc0", 64'(bus.out_pc_0), 64'd0);
    rst_n = 1'b1;

    drive(2'b11, 32'h1000, 2'b00); step();
    check("b11_valid", 64'(bus.out_valid), 64'd3);
    check("b11_pc0", 64'(bus.out_pc_0), 64'h1000);
    check("b11_pc1", 64'(bus.out_pc_1), 64'h1004);
    check("b11_count", 64'(bus.count), 64'd2);
    drive(2'b00, 32'h0, 2'b11); step();

    drive(2'b10, 32'h2000, 2'b00); step();
    check("b10_valid", 64'(bus.out_valid), 64'd1);
    check("b10_pc0", 64'(bus.out_pc_0), 64'h2004);
    check("b10_inst0", 64'(bus.out_inst_0), 64'(f(32'h2004)));
    drive(2'b00, 32'h0, 2'b10); step();
    check("acc10_count", 64'(bus.count), 64'd1);
    drive(2'b00, 32'h0, 2'b11); step();
    check("acc11_one", 64'(bus.count), 64'd0);

    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h3000 + 32'(8 * k), 2'b00); step();
    end
    check("full_count", 64'(bus.count), 64'd8);
    check("full_ready", 64'(bus.in_ready), 64'd0);
    drive(2'b11, 32'h4000, 2'b00); step();
    check("drop_count", 64'(bus.count), 64'd8);
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 32'h0, 2'b11); step();
    end
    check("drain_count", 64'(bus.count), 64'd0);

    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'h5000 + 32'(8 * k), 2'b00); step();
    end
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, 32'h5018 + 32'(8 * k), 2'b11); step();
      check("wrap_count", 64'(bus.count), 64'd6);
      check("wrap_ready", 64'(bus.in_ready), 64'd1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 32'h0, 2'b11); step();
    end

    drive(2'b11, 32'h6000, 2'b00); step();
    drive(2'b11, 32'h6008, 2'b00); step();
    drive(2'b01, 32'h6010, 2'b00); step();
    check("pre_flush", 64'(bus.count), 64'd5);
    flush = 1'b1;
    drive(2'b11, 32'h6100, 2'b11); step();
    flush = 1'b0;
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ready", 64'(bus.in_ready), 64'd1);

`ifdef INST_BUFFER_BYPASS_EN
    drive(2'b11, 32'h7000, 2'b01);
    #1;
    check("byp_valid", 64'(bus.out_valid), 64'd3);
    check("byp_pc0", 64'(bus.out_pc_0), 64'h7000);
    step();
    check("byp_count", 64'(bus.count), 64'd1);
    check("byp_next_pc0", 64'(bus.out_pc_0), 64'h7004);
    drive(2'b00, 32'h0, 2'b01); step();
`endif

    drive(2'b11, 32'h8000, 2'b00); step();
    drive(2'b00, 32'h0, 2'b00);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    mdl_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(2'b01, 32'h9000, 2'b00); step();
    drive(2'b00, 32'h0, 2'b11); step();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-slot instruction buffer between the fetch stage and decode.
- Accepts a batch of up to 2 instructions per cycle, qualified by a valid mask, and queues them with their PCs in a circular FIFO.
- Presents the two oldest entries to decode, which consumes 0, 1 or 2 per cycle.
- Decouples fetch batching from decode throughput; flushed on redirect.

Parameters:
- INST_WIDTH, 32, instruction width in bits.
- ADDR_WIDTH, 32, PC width in bits.
- DEPTH, 8, number of entries; power of 2, minimum 4.
- PC_STEP, 4, byte distance between slot 0 and slot 1 of an input batch.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all entries (branch/exception redirect).
- in_inst_0  in  INST_WIDTH  fetched instruction, batch slot 0.
- in_inst_1  in  INST_WIDTH  fetched instruction, batch slot 1.
- in_pc  in  ADDR_WIDTH  PC of slot 0; slot 1 PC = in_pc + PC_STEP.
- in_valid  in  2  per-slot valid mask from fetch.
- in_ready  out  1  buffer can take a full batch this cycle.
- out_inst_0  out  INST_WIDTH  oldest entry.
- out_inst_1  out  INST_WIDTH  second-oldest entry.
- out_pc_0  out  ADDR_WIDTH  PC of oldest entry.
- out_pc_1  out  ADDR_WIDTH  PC of second-oldest entry.
- out_valid  out  2  bit0 = count≥1, bit1 = count≥2.
- out_accept  in  2  decode consume mask; legal values 00, 01, 11.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- **Storage and pointers**
  - Storage: DEPTH entries of {inst, pc}.
  - head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH.
  - count register of log2(DEPTH)+1 bits, range 0..DEPTH.
- **Reset (async)**
  - head=tail=count=0.
  - out_valid=00, in_ready=1.
  - out_inst_*/out_pc_* drive 0 while not valid.
- **in_ready**
  - in_ready = (DEPTH − count) ≥ 2, computed from registered count only.
  - Not dependent on same-cycle out_accept; no combinational ready/accept loop.
- **Push** (when in_ready=1):
  - 00: nothing written.
  - 01: write slot 0 at tail; tail+1.
  - 11: write slot 0 at tail and slot 1 (pc = in_pc + PC_STEP) at tail+1; tail+2.
  - 10: write slot 1 only, with its pc, at tail; tail+1. Entries are always compacted.
  - in_ready=0: input is dropped; fetch must hold the batch.
- **Pop**
  - out_* read combinationally from head and head+1, both modulo DEPTH.
  - out_accept 01 pops 1; 11 pops 2; head advances accordingly.
  - Accept bits beyond out_valid are ignored: 11 with count=1 pops 1.
  - out_accept=10 is illegal; pops 0.
- **Simultaneous push and pop**
  - count_next = count + pushes − pops.
  - Valid at full boundary: count=DEPTH−2 with push 2 and pop 2 → count stays DEPTH−2.
  - Entries freed by a pop become writable the next cycle, not the same cycle.
- **Flush**
  - head=tail=count=0 at the next edge.
  - Overrides push and pop in the same cycle; the input batch is discarded.
  - out_valid=00 from the following cycle.
- **Latency**: an instruction written at edge N is visible on out_* after edge N; one cycle minimum.
- **Ordering**: strict FIFO; slot 0 precedes slot 1 within a batch.
- **Reset mid-operation**: all state clears immediately; contents are lost.

Optional Feature:
- Macro: INST_BUFFER_BYPASS_EN.
- **Defined**, when count=0 and flush=0:
  - in_valid entries appear combinationally on out_* in compacted order, same cycle.
  - out_valid reflects the compacted in_valid.
  - Only entries not covered by out_accept are written; tail/count advance by the remainder.
  - Zero-cycle latency when empty. in_ready unchanged.
- **Not defined**: strict 1-cycle latency through storage; no in→out combinational path.

Test Plan:
- Reset, then push in_pc=0x1000, in_valid=11, out_accept=00 → next cycle: out_valid=11, out_pc_0=0x1000, out_pc_1=0x1004, count=2.
- Push in_valid=10, in_pc=0x2000, into empty buffer → out_valid=01, out_pc_0=0x2004, out_inst_0=in_inst_1.
- Fill DEPTH=8 with four 11 batches, out_accept=00 → count=8, in_ready=0; a fifth batch is dropped and count stays 8.
- Hold count=6; push 11 and accept 11 together for 10 cycles → count stays 6, in_ready=1, PCs in order across pointer wrap.
- count=5; assert flush with in_valid=11 and out_accept=11 → next cycle: count=0, out_valid=00, in_ready=1.
- With INST_BUFFER_BYPASS_EN, empty buffer, push 11 with out_accept=01 → same cycle out_valid=11; next cycle count=1, out_pc_0=in_pc+4.
